mat_add_nway: RTL

- N-input AXI-stream element-wise saturating adder/subtractor; generalises the two-operand matrix add to N_IN operands, each with a per-operand sign.
- Sits after the matmul/requant stages in the IBERT datapath: residual adds, bias merges and multi-branch sums.
- Adds a per-beat saturation sideband, a sticky tlast-misalignment error, and an optional saturation event counter.

---
 rtl/mat_add_nway_if.sv | 28 ++
 rtl/mat_add_nway.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mat_add_nway_if.sv
// Stream bundle for mat_add_nway: N_IN operand channels in, one saturated result out, plus status sideband.
interface mat_add_nway_if #(
  parameter int N_IN = 2,
  parameter int D_W  = 32
);
  logic [N_IN*D_W-1:0] in_tdata;
  logic [N_IN-1:0]     in_tvalid;
  logic [N_IN-1:0]     in_tlast;
  logic [N_IN-1:0]     in_tready;
  logic [D_W-1:0]      out_tdata;
  logic                out_tvalid;
  logic                out_tlast;
  logic                out_tready;
  logic                out_sat;
  logic                err_tlast;
  logic                err_clr;
  logic [15:0]         sat_cnt;

  modport master (
    output in_tdata, in_tvalid, in_tlast, out_tready, err_clr,
    input  in_tready, out_tdata, out_tvalid, out_tlast, out_sat, err_tlast, sat_cnt
  );

  modport slave (
    input  in_tdata, in_tvalid, in_tlast, out_tready, err_clr,
    output in_tready, out_tdata, out_tvalid, out_tlast, out_sat, err_tlast, sat_cnt
  );
endinterface

// File: rtl/mat_add_nway.sv
// N-input saturating add/sub over AXI-stream; optional saturation counter via MAT_ADD_NWAY_SAT_CNT_EN.
// 2-cycle latency, 1 beat/cycle; per-channel skid regs join on one fire, ready path only from out_tready.
module mat_add_nway #(
  parameter int              N_IN     = 2,
  parameter int              D_W      = 32,
  parameter int              MAX_BITS = 22,
  parameter logic [N_IN-1:0] SUB_MASK = '0
) (
  input logic           clk,
  input logic           rst_n,
  mat_add_nway_if.slave bus
);
  localparam int SW = D_W + $clog2(N_IN) + 1;
  localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (MAX_BITS - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic [N_IN-1:0]          v0_q, v0_d, l0_q, l0_d;
  logic [N_IN-1:0][D_W-1:0] d0_q, d0_d;
  logic [N_IN-1:0]          in_rdy;
  logic                     s0_valid, s1_ready, s0_fire, tl_mis;
  logic                     out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic                     out_sat_q, out_sat_d, err_q, err_d;
  logic [D_W-1:0]           out_dat_q, out_dat_d;
  logic signed [SW-1:0]     sum, opnd;
  logic [D_W-1:0]           j_dat;
  logic                     j_sat;

  assign s0_valid = &v0_q;
  assign s1_ready = bus.out_tready | ~out_vld_q;
  assign s0_fire  = s0_valid & s1_ready;
  assign in_rdy   = {N_IN{s0_fire}} | ~v0_q;
  assign tl_mis   = (|l0_q) & ~(&l0_q);

  always_comb begin
    v0_d = v0_q;
    l0_d = l0_q;
    d0_d = d0_q;
    for (int i = 0; i < N_IN; i++) begin
      if (in_rdy[i]) begin
        v0_d[i] = bus.in_tvalid[i];
        l0_d[i] = bus.in_tlast[i];
        d0_d[i] = bus.in_tdata[i*D_W +: D_W];
      end
    end
  end

  // SW leaves headroom for N_IN full-scale terms, including negation of the most negative input.
  always_comb begin
    sum  = '0;
    opnd = '0;
    for (int i = 0; i < N_IN; i++) begin
      opnd = {{(SW-D_W){d0_q[i][D_W-1]}}, d0_q[i]};
      if (SUB_MASK[i]) sum = sum - opnd;
      else             sum = sum + opnd;
    end
    j_sat = 1'b0;
    j_dat = sum[D_W-1:0];
    if (sum > SAT_MAX) begin
      j_sat = 1'b1;
      j_dat = SAT_MAX[D_W-1:0];
    end else if (sum < SAT_MIN) begin
      j_sat = 1'b1;
      j_dat = SAT_MIN[D_W-1:0];
    end
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    out_dat_d  = out_dat_q;
    out_sat_d  = out_sat_q;
    if (s1_ready) begin
      out_vld_d  = s0_valid;
      out_last_d = &l0_q;
      out_dat_d  = j_dat;
      out_sat_d  = j_sat;
    end
    err_d = err_q;
    if (s0_fire && tl_mis) err_d = 1'b1;
    else if (bus.err_clr)  err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q       <= '0;
      l0_q       <= '0;
      d0_q       <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_dat_q  <= '0;
      out_sat_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      v0_q       <= v0_d;
      l0_q       <= l0_d;
      d0_q       <= d0_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_dat_q  <= out_dat_d;
      out_sat_q  <= out_sat_d;
      err_q      <= err_d;
    end
  end

`ifdef MAT_ADD_NWAY_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (bus.err_clr)
      sat_cnt_d = '0;
    else if (out_vld_q && bus.out_tready && out_sat_q && !(&sat_cnt_q))
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign bus.sat_cnt = sat_cnt_q;
`else
  assign bus.sat_cnt = '0;
`endif

  assign bus.in_tready  = in_rdy;
  assign bus.out_tvalid = out_vld_q;
  assign bus.out_tlast  = out_last_q;
  assign bus.out_tdata  = out_dat_q;
  assign bus.out_sat    = out_sat_q;
  assign bus.err_tlast  = err_q;
endmodule
